// File: rtl/position_loop_sequencer_if.sv
// Handshake bundle between the position-loop sequencer, the encoder front end
// and the position PI. The sequencer sits on the slave side.
interface position_loop_sequencer_if;
  logic [11:0]        iAngle;
  logic               iAngle_valid;
  logic               iZero;
  logic               iCal_done;
  logic signed [19:0] oCurrent_data;
  logic               oCal_en;
  logic               oPos_valid;
  logic               oOverrun;
  logic               oTimeout;

  modport master (
    output iAngle, iAngle_valid, iZero, iCal_done,
    input  oCurrent_data, oCal_en, oPos_valid, oOverrun, oTimeout
  );

  modport slave (
    input  iAngle, iAngle_valid, iZero, iCal_done,
    output oCurrent_data, oCal_en, oPos_valid, oOverrun, oTimeout
  );
endinterface

// File: rtl/position_loop_sequencer.sv
// Position-loop request sequencer: unwraps a 12-bit single-turn angle into a
// saturating 20-bit multi-turn position and, once per loop period, freezes it
// for the position PI and holds a request level until the PI answers.
module position_loop_sequencer #(
  parameter logic [15:0] LOOP_DIV = 16'd20000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input logic                      iClk,
  input logic                      iRst,
  position_loop_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;

  localparam logic signed [20:0] POS_MAX = 21'sd524287;
  localparam logic signed [20:0] POS_MIN = -21'sd524288;

  // Shortest signed angle step; a half-turn step lands on -2048.
  function automatic logic signed [12:0] wrap_delta(input logic [11:0] cur,
                                                    input logic [11:0] prv);
    logic signed [13:0] d;
    d = $signed({2'b00, cur}) - $signed({2'b00, prv});
    if (d > 14'sd2047)
      d = d - 14'sd4096;
    else if (d < -14'sd2048)
      d = d + 14'sd4096;
    return d[12:0];
  endfunction

  // Clamp a 21-bit sum to the 20-bit signed position range.
  function automatic logic signed [19:0] sat20(input logic signed [20:0] v);
    if (v > POS_MAX)
      return 20'sh7FFFF;
    else if (v < POS_MIN)
      return 20'sh80000;
    else
      return v[19:0];
  endfunction

  logic signed [19:0] pos;
  logic [11:0]        prev;
  logic               pos_valid;   // doubles as "first sample taken" marker
  logic [15:0]        div_cnt;
  logic               tick;

  state_t             state, state_d;
  logic               cal_en, cal_en_d;
  logic signed [19:0] cur_data, cur_data_d;
  logic [7:0]         wdog, wdog_d;
  logic               overrun, overrun_d;
  logic               timeout, timeout_d;

  assign tick = (div_cnt == LOOP_DIV - 16'd1);

  // Angle unwrap; zero request overrides a coincident angle sample.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      pos       <= '0;
      prev      <= '0;
      pos_valid <= 1'b0;
    end else if (bus.iZero) begin
      pos <= '0;
      if (bus.iAngle_valid) begin
        prev      <= bus.iAngle;
        pos_valid <= 1'b1;
      end else begin
        pos_valid <= 1'b0;
      end
    end else if (bus.iAngle_valid) begin
      prev      <= bus.iAngle;
      pos_valid <= 1'b1;
      if (pos_valid)
        pos <= sat20(21'(pos) + 21'(wrap_delta(bus.iAngle, prev)));
    end
  end

  // Free-running loop-period divider.
  always_ff @(posedge iClk) begin
    if (iRst || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 16'd1;
  end

  // Request FSM and output registers.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= IDLE;
      cal_en   <= 1'b0;
      cur_data <= '0;
      wdog     <= '0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_d;
      cal_en   <= cal_en_d;
      cur_data <= cur_data_d;
      wdog     <= wdog_d;
      overrun  <= overrun_d;
      timeout  <= timeout_d;
    end
  end

  // Next-state logic: snapshot on tick, wait for done or watchdog, one idle gap.
  always_comb begin
    state_d    = state;
    cal_en_d   = cal_en;
    cur_data_d = cur_data;
    wdog_d     = wdog;
    overrun_d  = overrun;
    timeout_d  = timeout;

    if (tick && (state != IDLE))
      overrun_d = 1'b1;

    case (state)
      IDLE: begin
        if (tick && pos_valid) begin
          cur_data_d = pos;
          cal_en_d   = 1'b1;
          wdog_d     = '0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.iCal_done) begin
          cal_en_d = 1'b0;
          state_d  = GAP;
        end else if (wdog == TIMEOUT - 8'd1) begin
          timeout_d = 1'b1;
          cal_en_d  = 1'b0;
          state_d   = GAP;
        end else begin
          wdog_d = wdog + 8'd1;
        end
      end
      GAP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign bus.oCurrent_data = cur_data;
  assign bus.oCal_en       = cal_en;
  assign bus.oPos_valid    = pos_valid;
  assign bus.oOverrun      = overrun;
  assign bus.oTimeout      = timeout;

endmodule

// File: tb/tb_position_loop_sequencer.sv
// Testbench for position_loop_sequencer: unwrap table, saturation, zeroing,
// timeout/overrun sequences and a randomized run against a reference model.
module tb_position_loop_sequencer;

  localparam int LD = 16;
  localparam int TO = 20;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  position_loop_sequencer_if bus();

  position_loop_sequencer #(
    .LOOP_DIV(16'(LD)),
    .TIMEOUT (8'(TO))
  ) dut (
    .iClk(clk),
    .iRst(rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [11:0] angle;
    logic        zero;
    int          exp_pos;
  } vec_t;

  vec_t tbl[8];

  // reference model state
  longint m_pos;
  int     m_prev;
  bit     m_valid;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clk_step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    bus.iAngle       = '0;
    bus.iAngle_valid = 1'b0;
    bus.iZero        = 1'b0;
    bus.iCal_done    = 1'b0;
    rst              = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic send(input int a, input bit z, input bit v);
    bus.iAngle       = 12'(a);
    bus.iAngle_valid = v;
    bus.iZero        = z;
    clk_step();
    bus.iAngle_valid = 1'b0;
    bus.iZero        = 1'b0;
  endtask

  task automatic wait_rise(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      clk_step();
      if (bus.oCal_en) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Retire any request already in flight, then check the next snapshot.
  task automatic snapshot(input string name, input longint exp);
    bit ok;
    for (int i = 0; i < 40 && bus.oCal_en; i++) begin
      bus.iCal_done = 1'b1;
      clk_step();
    end
    bus.iCal_done = 1'b0;
    wait_rise(40, ok);
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL %s: no request seen, expected snapshot %0d", name, exp);
    end else begin
      check(name, bus.oCurrent_data, exp);
    end
    bus.iCal_done = 1'b1;
    clk_step();
    bus.iCal_done = 1'b0;
  endtask

  function automatic longint model_delta(input int cur, input int prv);
    int d;
    d = cur - prv;
    d = (((d + 2048) % 4096) + 4096) % 4096 - 2048;
    return longint'(d);
  endfunction

  function automatic longint clamp20(input longint v);
    if (v > 524287) return 524287;
    if (v < -524288) return -524288;
    return v;
  endfunction

  task automatic model_apply(input bit v, input bit z, input int a);
    if (z) begin
      m_pos = 0;
      if (v) begin
        m_prev  = a;
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end else if (v) begin
      if (m_valid) m_pos = clamp20(m_pos + model_delta(a, m_prev));
      m_prev  = a;
      m_valid = 1'b1;
    end
  endtask

  initial begin
    bit     ok;
    int     a;
    int     rises;
    int     hi;
    bit     last_en;
    bit     rv, rz, rd, tick, rise, exp_rise, exp_valid;
    longint exp_data;
    int     lat, lat_cnt, a_last;

    checks   = 0;
    failures = 0;
    cyc      = 0;

    tbl[0] = '{12'd4000, 1'b0, 0};
    tbl[1] = '{12'd50,   1'b0, 146};
    tbl[2] = '{12'd100,  1'b0, 196};
    tbl[3] = '{12'd100,  1'b0, 196};
    tbl[4] = '{12'd0,    1'b0, 96};
    tbl[5] = '{12'd4090, 1'b0, 90};
    tbl[6] = '{12'd2042, 1'b0, -1958};
    tbl[7] = '{12'd4090, 1'b0, -4006};

    // ---- basic request timing after reset
    do_reset();
    check("rst_cal_en", longint'(bus.oCal_en), 0);
    check("rst_data", bus.oCurrent_data, 0);
    check("rst_pos_valid", longint'(bus.oPos_valid), 0);
    check("rst_overrun", longint'(bus.oOverrun), 0);
    check("rst_timeout", longint'(bus.oTimeout), 0);
    send(100, 1'b0, 1'b1);
    check("t1_pos_valid", longint'(bus.oPos_valid), 1);
    wait_rise(40, ok);
    check("t1_rise_cycle", ok ? cyc : -1, 16);
    check("t1_data", bus.oCurrent_data, 0);
    clk_step();
    check("t1_en_held", longint'(bus.oCal_en), 1);
    bus.iCal_done = 1'b1;
    clk_step();
    bus.iCal_done = 1'b0;
    check("t1_en_fall", longint'(bus.oCal_en), 0);
    clk_step();
    check("t1_en_gap", longint'(bus.oCal_en), 0);

    // ---- unwrap table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(int'(tbl[i].angle), tbl[i].zero, 1'b1);
      snapshot($sformatf("t2_step%0d", i), tbl[i].exp_pos);
    end

    // ---- positive saturation
    do_reset();
    a = 0;
    send(a, 1'b0, 1'b1);
    for (int k = 0; k < 200; k++) begin
      a = (a + 2000) % 4096;
      send(a, 1'b0, 1'b1);
    end
    snapshot("t3_mid", 400000);
    for (int k = 0; k < 70; k++) begin
      a = (a + 2000) % 4096;
      send(a, 1'b0, 1'b1);
    end
    snapshot("t3_clamp", 524287);
    a = (a + 4096 - 1000) % 4096;
    send(a, 1'b0, 1'b1);
    snapshot("t3_after_clamp", 523287);

    // ---- zeroing
    do_reset();
    send(0, 1'b0, 1'b1);
    send(2000, 1'b0, 1'b1);
    send(4000, 1'b0, 1'b1);
    send(904, 1'b0, 1'b1);
    snapshot("t6_pos5000", 5000);
    send(777, 1'b1, 1'b1);
    snapshot("t6_zero_with_angle", 0);
    send(780, 1'b0, 1'b1);
    snapshot("t6_after_zero", 3);
    if ((cyc + 1) % LD == 0) clk_step();
    send(0, 1'b1, 1'b0);
    check("t6_zero_only_valid", longint'(bus.oPos_valid), 0);
    wait_rise(20, ok);
    check("t6_no_request", longint'(ok), 0);
    send(10, 1'b0, 1'b1);
    snapshot("t6_first_after_zero", 0);

    // ---- randomized run against the reference model
    do_reset();
    m_pos = 0; m_prev = 0; m_valid = 1'b0;
    a_last = 0; lat = 2; lat_cnt = 0;
    for (int n = 0; n < 800; n++) begin
      rv = ($urandom_range(0, 2) != 0);
      rz = ($urandom_range(0, 39) == 0);
      case ($urandom_range(0, 9))
        0: a = int'($urandom_range(0, 4095));
        1: a = (a_last + 2048) % 4096;
        default: a = (a_last + int'($urandom_range(0, 400)) - 200 + 4096) % 4096;
      endcase
      if (rv) a_last = a;
      if (bus.oCal_en) begin
        lat_cnt++;
        rd = (lat_cnt > lat);
      end else begin
        lat_cnt = 0;
        lat = int'($urandom_range(0, 6));
        rd = 1'b0;
      end
      bus.iAngle       = 12'(a);
      bus.iAngle_valid = rv;
      bus.iZero        = rz;
      bus.iCal_done    = rd;
      tick     = ((cyc + 1) % LD == 0);
      exp_rise = tick && m_valid;
      exp_data = m_pos;
      model_apply(rv, rz, a);
      exp_valid = m_valid;
      last_en   = bus.oCal_en;
      clk_step();
      rise = bus.oCal_en && !last_en;
      check("rnd_rise", longint'(rise), longint'(exp_rise));
      if (exp_rise) check("rnd_data", bus.oCurrent_data, exp_data);
      check("rnd_pos_valid", longint'(bus.oPos_valid), longint'(exp_valid));
    end
    bus.iAngle_valid = 1'b0;
    bus.iZero        = 1'b0;
    bus.iCal_done    = 1'b0;
    check("rnd_no_overrun", longint'(bus.oOverrun), 0);
    check("rnd_no_timeout", longint'(bus.oTimeout), 0);

    // ---- late done: tick lands in REQ
    do_reset();
    send(100, 1'b0, 1'b1);
    wait_rise(40, ok);
    check("t5_rise_cycle", ok ? cyc : -1, 16);
    rises = 0;
    last_en = bus.oCal_en;
    while (cyc < 33) begin
      clk_step();
      if (bus.oCal_en && !last_en) rises++;
      last_en = bus.oCal_en;
    end
    check("t5_en_held", longint'(bus.oCal_en), 1);
    bus.iCal_done = 1'b1;
    clk_step();
    bus.iCal_done = 1'b0;
    check("t5_en_fall", longint'(bus.oCal_en), 0);
    check("t5_overrun", longint'(bus.oOverrun), 1);
    check("t5_no_timeout", longint'(bus.oTimeout), 0);
    last_en = bus.oCal_en;
    while (cyc < 47) begin
      clk_step();
      if (bus.oCal_en && !last_en) rises++;
      last_en = bus.oCal_en;
    end
    check("t5_extra_rises", rises, 0);
    clk_step();
    check("t5_reissue", longint'(bus.oCal_en), 1);
    bus.iCal_done = 1'b1;
    clk_step();
    bus.iCal_done = 1'b0;

    // ---- watchdog expiry, reissue, then reset mid-request
    do_reset();
    send(0, 1'b0, 1'b1);
    send(300, 1'b0, 1'b1);
    wait_rise(40, ok);
    check("t4_rise_cycle", ok ? cyc : -1, 16);
    check("t4_data", bus.oCurrent_data, 300);
    check("t4_timeout_clear", longint'(bus.oTimeout), 0);
    hi = 0;
    for (int i = 0; i < 40 && bus.oCal_en; i++) begin
      hi++;
      clk_step();
    end
    check("t4_en_high_clocks", hi, TO);
    check("t4_timeout_set", longint'(bus.oTimeout), 1);
    wait_rise(40, ok);
    check("t4_reissue_cycle", ok ? cyc : -1, 48);
    check("t4_reissue_data", bus.oCurrent_data, 300);
    rst = 1'b1;
    clk_step();
    rst = 1'b0;
    check("t6_rst_cal_en", longint'(bus.oCal_en), 0);
    check("t6_rst_data", bus.oCurrent_data, 0);
    check("t6_rst_pos_valid", longint'(bus.oPos_valid), 0);
    check("t6_rst_overrun", longint'(bus.oOverrun), 0);
    check("t6_rst_timeout", longint'(bus.oTimeout), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
